// File: rtl/z_line_rx_if.sv
// Shared line interface I: y frames the driven (low) and floating (high) windows, z is the tri-stated data line.
interface I;
  wire  z;
  logic y;

  modport rx (input z, input y);
endinterface

// File: rtl/z_line_rx.sv
// Far-end receiver for interface I: deserialises z during y-low windows into WIDTH-bit frames,
// presents them on a single-entry valid/ready buffer and flags line-discipline violations.
module z_line_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  I.rx                     u_I,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_err_drive,
  output logic             o_err_float,
  output logic             o_err_short,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_frame_cnt
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_FLOAT} state_e;

  state_e           state_q, state_d;
  logic             y_q, y_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_drive_q, err_drive_d;
  logic             err_float_q, err_float_d;
  logic             err_short_q, err_short_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic y, start, z_bad, z_bit, complete, load;

  // The float check looks for a true 'z'; the drive check also rejects 'x'.
  assign y     = u_I.y;
  assign start = y_q && !y;
  assign z_bad = (u_I.z === 1'bz) || ((u_I.z !== 1'b0) && (u_I.z !== 1'b1));
  assign z_bit = z_bad ? 1'b0 : u_I.z;

  // Bits enter at the top and shift down, so the first sampled bit lands in bit 0.
  always_comb begin
    state_d     = state_q;
    y_d         = y;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    err_drive_d = 1'b0;
    err_short_d = 1'b0;
    err_float_d = y && (u_I.z !== 1'bz);
    complete    = 1'b0;

    case (state_q)
      IDLE, WAIT_FLOAT: begin
        if (start) begin
          shift_d     = {z_bit, {(WIDTH-1){1'b0}}};
          bit_cnt_d   = BCW'(1);
          err_drive_d = z_bad;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (y) begin
          shift_d     = '0;
          bit_cnt_d   = '0;
          err_short_d = 1'b1;
          state_d     = WAIT_FLOAT;
        end else begin
          shift_d     = {z_bit, shift_q[WIDTH-1:1]};
          bit_cnt_d   = bit_cnt_q + BCW'(1);
          err_drive_d = z_bad;
          if (bit_cnt_q == LAST_BIT) begin
            complete = 1'b1;
            state_d  = WAIT_FLOAT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A completed frame may replace a buffered one only if that one is consumed in the same cycle.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    load        = complete && (!valid_q || i_ready);

    if (load) begin
      data_d      = shift_d;
      valid_d     = 1'b1;
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end else begin
      if (complete) overrun_d = 1'b1;
      if (valid_q && i_ready) valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      y_q         <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      err_drive_q <= 1'b0;
      err_float_q <= 1'b0;
      err_short_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      err_drive_q <= err_drive_d;
      err_float_q <= err_float_d;
      err_short_q <= err_short_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_err_drive = err_drive_q;
  assign o_err_float = err_float_q;
  assign o_err_short = err_short_q;
  assign o_overrun   = overrun_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_z_line_rx.sv
// Bench for z_line_rx: window-level stimulus predicts frames and error pulses; a monitor
// models the single-entry output buffer and compares every cycle.
module tb_z_line_rx;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ready = 1'b0;
  logic             z_en = 1'b0;
  logic             z_val = 1'b0;
  logic [WIDTH-1:0] o_data;
  logic             o_valid, o_err_drive, o_err_float, o_err_short, o_overrun;
  logic [CNT_W-1:0] o_frame_cnt;

  I bus();
  assign bus.z = z_en ? z_val : 1'bz;

  z_line_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .u_I         (bus),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (ready),
    .o_err_drive (o_err_drive),
    .o_err_float (o_err_float),
    .o_err_short (o_err_short),
    .o_overrun   (o_overrun),
    .o_frame_cnt (o_frame_cnt)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; inputs driven after edge n are sampled at edge n+1.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  logic rst_s, rdy_s;
  always @(posedge clk) begin
    rst_s <= rst;
    rdy_s <= ready;
  end

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] data;
  } comp_t;

  comp_t comp_q[$];
  bit    exp_drive[int];
  bit    exp_float[int];
  bit    exp_short[int];
  int    compared = 0;
  int    mismatched = 0;
  int    rdy_mode = 0;
  bit    pending_short = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  // Drives one cycle of inputs; tag is the edge at which the DUT samples them.
  task automatic applyStimulus(input logic y, input logic en, input logic val, input logic r,
                               output int tag);
    @(posedge clk);
    #1;
    bus.y = y;
    z_en  = en;
    z_val = val;
    rst   = r;
    case (rdy_mode)
      0:       ready = 1'b0;
      1:       ready = 1'b1;
      default: ready = 1'($urandom_range(0, 1));
    endcase
    tag = edge_cnt + 1;
  endtask

  // Floating window: every driven z is a float violation; an unfinished frame is reported on the first high cycle.
  task automatic highCycles(input int n, input logic [31:0] drv);
    int tag;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, drv[i], 1'($urandom_range(0, 1)), 1'b0, tag);
      if (drv[i]) exp_float[tag] = 1'b1;
      if (i == 0 && pending_short) exp_short[tag] = 1'b1;
      pending_short = 0;
    end
  endtask

  // One window: h high cycles, then l low cycles; flt marks floated low bits; rst_at (if >=0) resets at that low cycle.
  task automatic sendWindow(input int h, input int l, input logic [31:0] bits, input logic [31:0] flt,
                            input logic [31:0] drv, input int rst_at);
    int               tag;
    bit               armed;
    logic [WIDTH-1:0] acc;
    highCycles(h, drv);
    armed = (h > 0);
    acc   = '0;
    for (int j = 0; j < l; j++) begin
      applyStimulus(1'b0, !flt[j], bits[j], (j == rst_at), tag);
      if (j == rst_at) begin
        armed = 0;
      end else if (armed && j < WIDTH) begin
        if (flt[j]) exp_drive[tag] = 1'b1;
        acc[j] = flt[j] ? 1'b0 : bits[j];
        if (j == WIDTH - 1) comp_q.push_back('{cyc: tag, data: acc});
      end
    end
    pending_short = armed && (l < WIDTH);
  endtask

  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  logic             m_ovr = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  initial begin : monitor
    comp_t c;
    bit    has_c;
    forever begin
      @(negedge clk);
      has_c = 0;
      if (comp_q.size() > 0 && comp_q[0].cyc == edge_cnt) begin
        c     = comp_q.pop_front();
        has_c = 1;
      end
      if (rst_s) begin
        m_valid = 1'b0;
        m_data  = '0;
        m_ovr   = 1'b0;
        m_cnt   = '0;
      end else if (has_c && (!m_valid || rdy_s)) begin
        m_valid = 1'b1;
        m_data  = c.data;
        m_cnt   = m_cnt + 1'b1;
      end else begin
        if (has_c) m_ovr = 1'b1;
        if (m_valid && rdy_s) m_valid = 1'b0;
      end
      checkOutput("o_valid", 32'(o_valid), 32'(m_valid));
      checkOutput("o_data", 32'(o_data), 32'(m_data));
      checkOutput("o_overrun", 32'(o_overrun), 32'(m_ovr));
      checkOutput("o_frame_cnt", 32'(o_frame_cnt), 32'(m_cnt));
      checkOutput("o_err_drive", 32'(o_err_drive), 32'(exp_drive.exists(edge_cnt)));
      checkOutput("o_err_float", 32'(o_err_float), 32'(exp_float.exists(edge_cnt)));
      checkOutput("o_err_short", 32'(o_err_short), 32'(exp_short.exists(edge_cnt)));
    end
  end

  initial begin : stimulus
    int          tag;
    int          h, l, ra;
    logic [31:0] bits, flt, drv;
    bus.y = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, tag);
    pending_short = 0;

    $display("[TB] directed: basic frame, back-to-back handshakes, overrun");
    rdy_mode = 0;
    sendWindow(1, 5, 32'b1101, 32'h0, 32'h0, -1);
    rdy_mode = 1;
    sendWindow(1, 5, 32'h3, 32'h0, 32'h0, -1);
    sendWindow(1, 5, 32'hA, 32'h0, 32'h0, -1);
    sendWindow(1, 5, 32'hF, 32'h0, 32'h0, -1);
    rdy_mode = 0;
    sendWindow(1, 5, 32'h5, 32'h0, 32'h0, -1);
    sendWindow(1, 5, 32'h6, 32'h0, 32'h0, -1);
    rdy_mode = 1;

    $display("[TB] directed: float and drive violations, short window, mid-frame reset");
    sendWindow(1, 5, 32'hF, 32'b0100, 32'b1, -1);
    sendWindow(1, 2, 32'h3, 32'h0, 32'h0, -1);
    sendWindow(1, 5, 32'h9, 32'h0, 32'h0, -1);
    sendWindow(1, 5, 32'h7, 32'h0, 32'h0, 2);
    sendWindow(2, 5, 32'hC, 32'h0, 32'h0, -1);

    $display("[TB] randomized windows");
    for (int w = 0; w < 60; w++) begin
      rdy_mode = int'($urandom_range(0, 2));
      h    = int'($urandom_range(1, 3));
      l    = int'($urandom_range(1, 8));
      bits = $urandom;
      flt  = $urandom & $urandom & $urandom;
      drv  = $urandom & $urandom;
      ra   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1;
      sendWindow(h, l, bits, flt, drv, ra);
    end

    rdy_mode = 1;
    highCycles(3, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("completions drained", 32'(comp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/z_line_rx.md
Name: z_line_rx

Overview:
- Receiver at the far end of interface I.
- Samples the shared z line during the driven window (y low) and deserialises it into WIDTH-bit frames.
- Presents each frame on a single-entry valid/ready output buffer.
- Checks line discipline in both windows: z must be floated (4-state 'z') while y is high, and must be driven to a known 0/1 while y is low.

Parameters:
WIDTH, 4, bits per frame (2..32); must not exceed the number of y-low cycles in one window.
CNT_W, 8, width of the completed-frame counter.

Ports:
i_clk  input  1  clock; all logic on posedge.
i_rst  input  1  synchronous, active-high reset.
u_I  interface I  -  reads u_I.z and u_I.y only; never drives either.
o_data  output  WIDTH  received frame, bit 0 = first sampled bit.
o_valid  output  1  o_data holds an unconsumed frame.
i_ready  input  1  consumer accepts o_data when o_valid && i_ready.
o_err_drive  output  1  one-cycle pulse: z is x/z during a shift cycle.
o_err_float  output  1  one-cycle pulse: z is not 'z' while y == 1.
o_err_short  output  1  one-cycle pulse: y rose before WIDTH bits were collected.
o_overrun  output  1  sticky: a completed frame was dropped.
o_frame_cnt  output  CNT_W  count of frames loaded into the buffer; wraps.

Behaviour:
- Reset values (registered, synchronous on i_rst=1):
  - State IDLE; y_q=0; shift register 0; bit_cnt 0.
  - o_data=0, o_valid=0, all error pulses 0, o_overrun=0, o_frame_cnt=0.
- y_q is y registered each cycle. Start event = y_q==1 && y==0 (falling edge of y).
- IDLE: wait for a start event. Reset mid-frame therefore discards the partial frame, and reception resumes only after the next full float window.
- Start event (from IDLE or WAIT_FLOAT):
  - Sample z as bit 0.
  - bit_cnt=1; go to SHIFT. If WIDTH bits are now complete, go directly to the complete handling.
- SHIFT, y==0: sample z into bit position bit_cnt; bit_cnt++.
  - If z is x or z: store 0 and pulse o_err_drive in the next cycle.
  - When bit_cnt reaches WIDTH, the frame is complete in that cycle; go to WAIT_FLOAT.
- SHIFT, y==1 before completion:
  - Discard the partial frame and pulse o_err_short.
  - Go to WAIT_FLOAT and perform the float check in that cycle.
- WAIT_FLOAT:
  - Extra y-low bits after WIDTH are ignored (no sampling, no errors).
  - Each cycle with y==1: if z !== 1'bz, pulse o_err_float.
  - The next start event re-enters SHIFT.
- The float check also applies in IDLE whenever y==1.
- Frame complete (registered, visible the cycle after the last bit is sampled):
  - If !o_valid, or o_valid && i_ready in the same cycle: load o_data, set o_valid, o_frame_cnt++ (wraps at 2^CNT_W).
  - Else: keep the old o_data/o_valid, set o_overrun, leave o_frame_cnt unchanged.
- Handshake:
  - o_valid && i_ready with no simultaneous load: clear o_valid; o_data holds its last value.
  - o_data is stable while o_valid && !i_ready.
- Error pulses: exactly one cycle each, one per offending sample cycle; these are not sticky.
- Latency: last bit sampled in cycle N → o_valid=1 in cycle N+1.

Test Plan:
1. Reset, then y pattern 1 high / 5 low (period 6), WIDTH=4; z driven 1,0,1,1 in the first four low cycles and 'z' while y high → o_data=4'b1101, o_valid one cycle after the 4th bit, o_frame_cnt=1, no errors.
2. Same pattern, i_ready held 1 for 3 frames with data 4'h3, 4'hA, 4'hF → three handshakes carrying 3, A, F; o_frame_cnt=3; o_overrun=0.
3. i_ready held 0 across two frames (first 4'h5, second 4'h6) → o_data stays 5, o_overrun=1, o_frame_cnt=1; then i_ready=1 → o_valid drops, o_frame_cnt remains 1.
4. z driven 1'b1 (not floated) during a y-high cycle → o_err_float one-cycle pulse; with z=x on bit 2 → o_err_drive pulse, received bit 2 = 0.
5. y low for only 2 cycles before rising, WIDTH=4 → o_err_short pulse, no o_valid, o_frame_cnt unchanged; the next full window is received correctly.
6. Assert i_rst for one cycle after bit 1 of a frame → all outputs 0; that frame is not delivered; the next frame after a y high→low edge is received correctly.
